ahb_lite_mem_slave: RTL and testbench

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

---
 rtl/ahb_lite_mem_slave.sv | 168 ++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-addressed memory slave with programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
module ahb_lite_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int TOP       = LANE_BITS + IDX_W;

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t                state, state_next;
    logic [3:0]            wait_cnt, wait_cnt_next;
    logic                  last_cycle, accept, accept_ok, accept_err;
    logic                  size_err, align_err, range_err;
    logic [LANE_BITS-1:0]  lane_q;
    logic [IDX_W-1:0]      idx_q, haddr_idx, rd_idx;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, bit_mask, rd_word;
    logic [BYTES-1:0]      byte_en;
    logic                  commit, rd_load;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
    assign haddr_idx     = HADDR[TOP-1:LANE_BITS];

    // Accepting only on the last cycle of a data phase keeps a stray HREADY
    // from a multi-slave fabric from clobbering a transfer in progress.
    assign last_cycle = (state == IDLE) || (state == ERR2) ||
                        ((state == DATA) && (wait_cnt == 4'd0));
    assign accept     = HSEL && HREADY && HTRANS[1] && last_cycle;
    assign accept_err = accept && (size_err || align_err || range_err);
    assign accept_ok  = accept && !(size_err || align_err || range_err);

    assign size_err = (HSIZE > 3'(LANE_BITS));

    always_comb begin
        case (HSIZE)
            3'd0:    align_err = 1'b0;
            3'd1:    align_err = HADDR[0];
            3'd2:    align_err = |HADDR[1:0];
            3'd3:    align_err = |HADDR[2:0];
            default: align_err = 1'b0;
        endcase
    end

    // MEM_DEPTH is a power of two, so out-of-range means any bit above the index is set.
    generate
        if (ADDR_WIDTH > TOP) begin : g_range
            assign range_err = |HADDR[ADDR_WIDTH-1:TOP];
        end else begin : g_norange
            assign range_err = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        HREADYOUT     = 1'b1;
        HRESP         = 1'b0;
        case (state)
            IDLE: ;
            DATA: begin
                if (wait_cnt != 4'd0) begin
                    HREADYOUT     = 1'b0;
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ERR2;
            end
            ERR2: HRESP = 1'b1;
            default: state_next = IDLE;
        endcase
        if (last_cycle) begin
            if (accept_ok) begin
                state_next    = DATA;
                wait_cnt_next = 4'(WAIT_STATES);
            end else if (accept_err) begin
                state_next = ERR1;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        byte_en  = '0;
        bit_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            if ((b >= int'(lane_q)) && (b < int'(lane_q) + (1 << size_q)))
                byte_en[b] = 1'b1;
            bit_mask[8*b +: 8] = {8{byte_en[b]}};
        end
    end

    assign commit  = (state == DATA) && (wait_cnt == 4'd0) && write_q && !HRESET;
    assign rd_load = (accept_ok && !HWRITE && (WAIT_STATES == 0)) ||
                     ((state == DATA) && !write_q && (wait_cnt == 4'd1));
    assign rd_idx  = ((state == DATA) && (wait_cnt != 4'd0)) ? idx_q : haddr_idx;

    // A write committing on the same edge a read loads is merged in here.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx))
            rd_word = (rd_word & ~bit_mask) | (HWDATA & bit_mask);
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b])
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            rdata_q  <= '0;
            lane_q   <= '0;
            idx_q    <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                lane_q  <= HADDR[LANE_BITS-1:0];
                idx_q   <= haddr_idx;
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
            if (rd_load)
                rdata_q <= rd_word;
        end
    end

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Scoreboard bench: the driver queues expected responses at address-phase
// acceptance, a negedge monitor pops and checks each completed data phase.
module tb_ahb_lite_mem_slave;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;
        bit          abort;
        int          id;
    } exp_t;

    logic        clk;
    logic        hreset;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3;
    logic        resp0, resp3;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          next_id  = 0;

    ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans), .HBURST(3'd0),
        .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(ready0), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_lite_mem_slave #(.WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans), .HBURST(3'd0),
        .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(ready3), .HWDATA(hwdata),
        .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 of the first data-phase cycle.
    task automatic issue(input bit d3, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input bit err, input logic [31:0] rdata, input bit abort);
        int   n;
        exp_t e;
        hsel0  = !d3;
        hsel3  = d3;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        n = 0;
        @(negedge clk);
        while (!(d3 ? ready3 : ready0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            n_checks++;
            $display("FAIL accept_timeout_%0d: HREADYOUT stayed 0, required 1", next_id);
        end
        @(posedge clk);
        #1;
        e.err   = err;
        e.rd    = !wr;
        e.data  = rdata;
        e.waits = err ? 1 : (d3 ? 3 : 0);
        e.abort = abort;
        e.id    = next_id;
        next_id++;
        q.push_back(e);
        hwdata = wdata;
        htrans = 2'b00;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
    endtask

    task automatic idle(input int n);
        htrans = 2'b00;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit          in_fl = 1'b0;
    bit          fl_d3 = 1'b0;
    int          waits = 0;
    logic        m_rdy, m_rsp;
    logic [31:0] m_rd;
    exp_t        m_e;

    always @(negedge clk) begin
        m_rdy = fl_d3 ? ready3 : ready0;
        m_rsp = fl_d3 ? resp3  : resp0;
        m_rd  = fl_d3 ? rdata3 : rdata0;
        if (in_fl) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: transfer with no expectation");
                in_fl = 1'b0;
            end else if (hreset) begin
                m_e = q.pop_front();
                if (!m_e.abort) begin
                    n_checks++;
                    $display("FAIL unexpected_abort_%0d: reset hit an unplanned transfer", m_e.id);
                end
                in_fl = 1'b0;
            end else if (!m_rdy) begin
                m_e = q[0];
                waits++;
                chk($sformatf("wait_resp_%0d", m_e.id), {31'd0, m_rsp}, {31'd0, m_e.err});
            end else begin
                m_e = q.pop_front();
                chk($sformatf("resp_%0d", m_e.id), {31'd0, m_rsp}, {31'd0, m_e.err});
                chk($sformatf("waits_%0d", m_e.id), waits, m_e.waits);
                if (m_e.rd && !m_e.err)
                    chk($sformatf("rdata_%0d", m_e.id), m_rd, m_e.data);
                in_fl = 1'b0;
            end
        end
        if (hreset) begin
            in_fl = 1'b0;
        end else if (!in_fl) begin
            if (hsel0 && ready0 && htrans[1]) begin
                in_fl = 1'b1; fl_d3 = 1'b0; waits = 0;
            end else if (hsel3 && ready3 && htrans[1]) begin
                in_fl = 1'b1; fl_d3 = 1'b1; waits = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        htrans = 2'b00;
        hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;

        chk("rst_ready0", {31'd0, ready0}, 32'd1);
        chk("rst_resp0",  {31'd0, resp0},  32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_ready3", {31'd0, ready3}, 32'd1);
        chk("rst_resp3",  {31'd0, resp3},  32'd0);
        chk("rst_rdata3", rdata3, 32'h0);

        // zero-wait slave: back-to-back write/read with forwarding
        issue(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF, 0);
        issue(0, 1, 32'h10, 3'd2, 32'h11223344, 0, 32'h0, 0);
        issue(0, 1, 32'h13, 3'd0, 32'hAA000000, 0, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA223344, 0);
        issue(0, 1, 32'h10, 3'd1, 32'h00005566, 0, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA225566, 0);
        // out of range, misaligned half, oversize: all ERROR with no write
        issue(0, 0, 32'h1000, 3'd2, 32'h0, 1, 32'h0, 0);
        issue(0, 1, 32'h11, 3'd1, 32'hFFFFFFFF, 1, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA225566, 0);
        issue(0, 1, 32'h10, 3'd3, 32'hFFFFFFFF, 1, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA225566, 0);
        // last legal word
        issue(0, 1, 32'hFFC, 3'd2, 32'hCAFEF00D, 0, 32'h0, 0);
        issue(0, 0, 32'hFFC, 3'd2, 32'h0, 0, 32'hCAFEF00D, 0);
        // byte lane 2 forwarded into an immediately following read
        issue(0, 1, 32'h12, 3'd0, 32'h00770000, 0, 32'h0, 0);
        issue(0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA775566, 0);
        idle(3);

        // three-wait slave; the read is presented throughout the write's waits
        issue(1, 1, 32'h20, 3'd2, 32'h12345678, 0, 32'h0, 0);
        issue(1, 0, 32'h20, 3'd2, 32'h0, 0, 32'h12345678, 0);
        issue(1, 0, 32'h1000, 3'd2, 32'h0, 1, 32'h0, 0);
        idle(3);

        // reset during the second wait cycle of a write
        issue(1, 1, 32'h20, 3'd2, 32'hFFFFFFFF, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        chk("post_rst_ready3", {31'd0, ready3}, 32'd1);
        chk("post_rst_resp3",  {31'd0, resp3},  32'd0);
        chk("post_rst_rdata3", rdata3, 32'h0);
        issue(1, 0, 32'h20, 3'd2, 32'h0, 0, 32'h12345678, 0);
        idle(8);

        chk("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
